mem_access_rmw: RTL and testbench

- MEM-stage data-memory access unit between the EX/MEM pipeline register and the single-port, synchronous-read data RAM.
- Word stores complete in one cycle.
- Byte and halfword stores (sb/sh) use a two-cycle read-modify-write; this is the one-cycle MEM-stage occupancy the hazard unit covers with its sb/sh stall.
- Loads are issued to RAM and returned next cycle, lane-aligned and sign- or zero-extended for MEM/WB.

---
 rtl/mem_access_rmw.sv | 178 +++++++++++++++++
 tb/tb_mem_access_rmw.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_rmw.sv
// MEM-stage data-memory access: single-cycle word stores, two-cycle read-modify-write for
// sb/sh, and load return with lane alignment and sign/zero extension.
module mem_access_rmw #(
    parameter int unsigned RAM_AW = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ex_mem_memRead,
    input  logic              ex_mem_memWrite,
    input  logic [1:0]        ex_mem_maskMode,
    input  logic              ex_mem_sext,
    input  logic [31:0]       ex_mem_addr,
    input  logic [31:0]       ex_mem_wdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_re,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              mem_busy,
    output logic              ld_valid,
    output logic [31:0]       mem_rdata,
    output logic              misalign
);

    typedef enum logic [0:0] {StIdle, StMerge} state_e;

    state_e            r_state;
    logic [RAM_AW-1:0] r_st_addr;
    logic [1:0]        r_st_off;
    logic              r_st_half;
    logic [15:0]       r_st_data;
    logic              r_ld_valid;
    logic [1:0]        r_ld_off;
    logic [1:0]        r_ld_mode;
    logic              r_ld_sext;
    logic              r_misalign;

    logic              w_req;
    logic              w_store;
    logic              w_sub_word;
    logic              w_misal;
    logic [RAM_AW-1:0] w_word_addr;
    logic [31:0]       w_merged;
    logic [7:0]        w_ld_byte;
    logic [15:0]       w_ld_half;
    logic              w_unused_addr;

    assign w_unused_addr = ^ex_mem_addr[31:RAM_AW+2];

    assign w_req       = ex_mem_memRead | ex_mem_memWrite;
    assign w_store     = ex_mem_memWrite;
    assign w_sub_word  = ~ex_mem_maskMode[1];
    assign w_word_addr = ex_mem_addr[RAM_AW+1:2];

    // Mode 3 is reserved and handled exactly like a word access.
    always_comb begin
        w_misal = 1'b0;
        unique case (ex_mem_maskMode)
            2'd0:    w_misal = 1'b0;
            2'd1:    w_misal = ex_mem_addr[0];
            default: w_misal = (ex_mem_addr[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        w_merged = ram_rdata;
        if (r_st_half) begin
            if (r_st_off[1]) begin
                w_merged[31:16] = r_st_data;
            end else begin
                w_merged[15:0] = r_st_data;
            end
        end else begin
            unique case (r_st_off)
                2'd0: w_merged[7:0]   = r_st_data[7:0];
                2'd1: w_merged[15:8]  = r_st_data[7:0];
                2'd2: w_merged[23:16] = r_st_data[7:0];
                2'd3: w_merged[31:24] = r_st_data[7:0];
                default: w_merged = ram_rdata;
            endcase
        end
    end

    // RAM strobes are gated by reset_n so nothing reaches the RAM while reset is held.
    always_comb begin
        ram_addr  = w_word_addr;
        ram_wdata = ex_mem_wdata;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        mem_busy  = 1'b0;
        if (r_state == StMerge) begin
            ram_addr  = r_st_addr;
            ram_wdata = w_merged;
            ram_we    = reset_n;
            mem_busy  = reset_n;
        end else if (reset_n && w_req && !w_misal) begin
            if (w_store) begin
                if (w_sub_word) begin
                    ram_re   = 1'b1;
                    mem_busy = 1'b1;
                end else begin
                    ram_we = 1'b1;
                end
            end else begin
                ram_re = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_st_addr  <= '0;
            r_st_off   <= 2'b00;
            r_st_half  <= 1'b0;
            r_st_data  <= 16'h0;
            r_ld_valid <= 1'b0;
            r_ld_off   <= 2'b00;
            r_ld_mode  <= 2'b00;
            r_ld_sext  <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_ld_valid <= 1'b0;
            r_misalign <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_req) begin
                        if (w_misal) begin
                            r_misalign <= 1'b1;
                        end else if (w_store) begin
                            if (w_sub_word) begin
                                r_st_addr <= w_word_addr;
                                r_st_off  <= ex_mem_addr[1:0];
                                r_st_half <= ex_mem_maskMode[0];
                                r_st_data <= ex_mem_wdata[15:0];
                                r_state   <= StMerge;
                            end
                        end else begin
                            r_ld_valid <= 1'b1;
                            r_ld_off   <= ex_mem_addr[1:0];
                            r_ld_mode  <= ex_mem_maskMode;
                            r_ld_sext  <= ex_mem_sext;
                        end
                    end
                end
                StMerge: r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    // Extraction uses only the latched load fields, so a store issued the next cycle is harmless.
    always_comb begin
        unique case (r_ld_off)
            2'd0:    w_ld_byte = ram_rdata[7:0];
            2'd1:    w_ld_byte = ram_rdata[15:8];
            2'd2:    w_ld_byte = ram_rdata[23:16];
            2'd3:    w_ld_byte = ram_rdata[31:24];
            default: w_ld_byte = ram_rdata[7:0];
        endcase
        w_ld_half = r_ld_off[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    end

    always_comb begin
        mem_rdata = 32'h0;
        if (r_ld_valid) begin
            unique case (r_ld_mode)
                2'd0:    mem_rdata = {{24{r_ld_sext & w_ld_byte[7]}}, w_ld_byte};
                2'd1:    mem_rdata = {{16{r_ld_sext & w_ld_half[15]}}, w_ld_half};
                default: mem_rdata = ram_rdata;
            endcase
        end
    end

    assign ld_valid = r_ld_valid;
    assign misalign = r_misalign;

endmodule

// File: tb/tb_mem_access_rmw.sv
// Bench for mem_access_rmw: directed scenarios plus a randomized run checked against a
// byte-addressed memory model.
module tb_mem_access_rmw;

    localparam int unsigned RAM_AW = 10;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              ex_mem_memRead;
    logic              ex_mem_memWrite;
    logic [1:0]        ex_mem_maskMode;
    logic              ex_mem_sext;
    logic [31:0]       ex_mem_addr;
    logic [31:0]       ex_mem_wdata;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_re;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              mem_busy;
    logic              ld_valid;
    logic [31:0]       mem_rdata;
    logic              misalign;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ram [0:(1<<RAM_AW)-1];
    logic [7:0]  ref_mem [0:4095];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= ram[ram_addr];
    end

    mem_access_rmw #(.RAM_AW(RAM_AW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ex_mem_memRead  (ex_mem_memRead),
        .ex_mem_memWrite (ex_mem_memWrite),
        .ex_mem_maskMode (ex_mem_maskMode),
        .ex_mem_sext     (ex_mem_sext),
        .ex_mem_addr     (ex_mem_addr),
        .ex_mem_wdata    (ex_mem_wdata),
        .ram_addr        (ram_addr),
        .ram_re          (ram_re),
        .ram_we          (ram_we),
        .ram_wdata       (ram_wdata),
        .ram_rdata       (ram_rdata),
        .mem_busy        (mem_busy),
        .ld_valid        (ld_valid),
        .mem_rdata       (mem_rdata),
        .misalign        (misalign)
    );

    task automatic drive(input logic rd, input logic wr, input logic [1:0] mode,
                         input logic sx, input logic [31:0] addr, input logic [31:0] wdata);
        ex_mem_memRead  = rd;
        ex_mem_memWrite = wr;
        ex_mem_maskMode = mode;
        ex_mem_sext     = sx;
        ex_mem_addr     = addr;
        ex_mem_wdata    = wdata;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic void ref_store(input logic [31:0] a, input int unsigned sz,
                                      input logic [31:0] d);
        for (int b = 0; b < int'(sz); b++) ref_mem[12'(a + 32'(b))] = d[8*b +: 8];
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_mem[12'(a + 3)], ref_mem[12'(a + 2)], ref_mem[12'(a + 1)], ref_mem[12'(a)]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int unsigned sz,
                                             input bit sx);
        logic [31:0] v = 32'h0;
        for (int b = 0; b < int'(sz); b++) v = v | (32'(ref_mem[12'(a + 32'(b))]) << (8*b));
        if (sx && sz < 4 && v[8*sz-1]) v = v | (32'hFFFFFFFF << (8*sz));
        return v;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        step();
        step();
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678);
        sample();
        n_checks++;
        if ({ram_re, ram_we, mem_busy} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_strobes got %b want %b", {ram_re, ram_we, mem_busy}, 3'b000);
        end
        n_checks++;
        if ({ld_valid, misalign, mem_rdata} !== 34'h0) begin
            n_errors++;
            $display("FAIL reset_outputs got %h want %h", {ld_valid, misalign, mem_rdata}, 34'h0);
        end
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        step();
        reset_n = 1'b1;
        idle();
        sample();
        n_checks++;
        if ({ld_valid, misalign, mem_rdata} !== 34'h0) begin
            n_errors++;
            $display("FAIL reset_no_load got %h want %h", {ld_valid, misalign, mem_rdata}, 34'h0);
        end
        step();
    endtask

    task automatic test_sb();
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hAABBCCDD);
        step();
        drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h12, 32'h11);
        sample();
        n_checks++;
        if ({ram_re, ram_we, mem_busy, ram_addr} !== {3'b101, 10'd4}) begin
            n_errors++;
            $display("FAIL sb_issue got %b/%0d want 101/4", {ram_re, ram_we, mem_busy}, ram_addr);
        end
        step();
        // Junk inputs during the merge cycle must be ignored.
        drive(1'b1, 1'b1, 2'd0, 1'b1, 32'h1, 32'hFFFFFFFF);
        sample();
        n_checks++;
        if ({ram_re, ram_we, mem_busy, ram_addr, ram_wdata} !== {3'b011, 10'd4, 32'hAA11CCDD}) begin
            n_errors++;
            $display("FAIL sb_merge got %b/%0d/%h want 011/4/aa11ccdd",
                     {ram_re, ram_we, mem_busy}, ram_addr, ram_wdata);
        end
        step();
        idle();
        sample();
        n_checks++;
        if ({ram_re, ram_we, mem_busy} !== 3'b000) begin
            n_errors++;
            $display("FAIL sb_back_idle got %b want %b", {ram_re, ram_we, mem_busy}, 3'b000);
        end
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        step();
        idle();
        sample();
        n_checks++;
        if ({ld_valid, mem_rdata} !== {1'b1, 32'hAA11CCDD}) begin
            n_errors++;
            $display("FAIL sb_readback got %b/%h want 1/aa11ccdd", ld_valid, mem_rdata);
        end
        step();
    endtask

    task automatic test_sh();
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hAABBCCDD);
        step();
        drive(1'b0, 1'b1, 2'd1, 1'b0, 32'h12, 32'h1234BEEF);
        sample();
        n_checks++;
        if ({ram_re, ram_we, mem_busy} !== 3'b101) begin
            n_errors++;
            $display("FAIL sh_issue got %b want %b", {ram_re, ram_we, mem_busy}, 3'b101);
        end
        step();
        idle();
        sample();
        n_checks++;
        if ({ram_we, ram_wdata} !== {1'b1, 32'hBEEFCCDD}) begin
            n_errors++;
            $display("FAIL sh_merge got %b/%h want 1/beefccdd", ram_we, ram_wdata);
        end
        step();
        drive(1'b0, 1'b1, 2'd1, 1'b0, 32'h11, 32'h5555);
        sample();
        n_checks++;
        if ({ram_re, ram_we, mem_busy, misalign} !== 4'b0000) begin
            n_errors++;
            $display("FAIL sh_misal_issue got %b want %b", {ram_re, ram_we, mem_busy, misalign},
                     4'b0000);
        end
        step();
        idle();
        sample();
        n_checks++;
        if ({misalign, ram_re, ram_we} !== 3'b100) begin
            n_errors++;
            $display("FAIL sh_misal_pulse got %b want %b", {misalign, ram_re, ram_we}, 3'b100);
        end
        step();
        sample();
        n_checks++;
        if (misalign !== 1'b0) begin
            n_errors++;
            $display("FAIL sh_misal_end got %b want %b", misalign, 1'b0);
        end
        step();
    endtask

    task automatic test_loads();
        logic [31:0] la [4] = '{32'h31, 32'h32, 32'h33, 32'h32};
        logic [1:0]  lm [4] = '{2'd0, 2'd0, 2'd0, 2'd1};
        logic        ls [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] le [4] = '{32'h0000007F, 32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF};
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h80FF7F01);
        step();
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) drive(1'b1, 1'b0, lm[i], ls[i], la[i], 32'h0);
            else idle();
            sample();
            if (i > 0) begin
                n_checks++;
                if ({ld_valid, mem_rdata} !== {1'b1, le[i-1]}) begin
                    n_errors++;
                    $display("FAIL load_ext_%0d got %b/%h want 1/%h", i - 1, ld_valid, mem_rdata,
                             le[i-1]);
                end
            end
            step();
        end
        sample();
        n_checks++;
        if ({ld_valid, mem_rdata} !== 33'h0) begin
            n_errors++;
            $display("FAIL load_valid_drop got %b/%h want 0/0", ld_valid, mem_rdata);
        end
        // Store right after a load must not disturb the returning load result.
        drive(1'b1, 1'b0, 2'd0, 1'b1, 32'h31, 32'h0);
        step();
        drive(1'b0, 1'b1, 2'd1, 1'b0, 32'h32, 32'h0000ABCD);
        sample();
        n_checks++;
        if ({ld_valid, mem_rdata, mem_busy} !== {1'b1, 32'h7F, 1'b1}) begin
            n_errors++;
            $display("FAIL store_after_load got %b/%h/%b want 1/7f/1", ld_valid, mem_rdata,
                     mem_busy);
        end
        step();
        idle();
        step();
    endtask

    task automatic test_sw_lw();
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF);
        sample();
        n_checks++;
        if ({ram_re, ram_we, mem_busy, ram_addr, ram_wdata} !== {3'b010, 10'd8, 32'hDEADBEEF}) begin
            n_errors++;
            $display("FAIL sw_issue got %b/%0d/%h want 010/8/deadbeef",
                     {ram_re, ram_we, mem_busy}, ram_addr, ram_wdata);
        end
        step();
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        sample();
        n_checks++;
        if ({ram_re, ram_we, mem_busy} !== 3'b100) begin
            n_errors++;
            $display("FAIL lw_issue got %b want %b", {ram_re, ram_we, mem_busy}, 3'b100);
        end
        step();
        idle();
        sample();
        n_checks++;
        if ({ld_valid, mem_rdata, mem_busy} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            n_errors++;
            $display("FAIL lw_result got %b/%h/%b want 1/deadbeef/0", ld_valid, mem_rdata, mem_busy);
        end
        step();
    endtask

    task automatic test_reset_in_merge();
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678);
        step();
        drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h41, 32'h99);
        step();
        reset_n = 1'b0;
        idle();
        sample();
        n_checks++;
        if ({ram_re, ram_we, mem_busy} !== 3'b000) begin
            n_errors++;
            $display("FAIL merge_reset_strobes got %b want %b", {ram_re, ram_we, mem_busy}, 3'b000);
        end
        step();
        reset_n = 1'b1;
        sample();
        n_checks++;
        if ({ld_valid, ram_re, ram_we, mem_busy} !== 4'b0000) begin
            n_errors++;
            $display("FAIL merge_reset_idle got %b want %b", {ld_valid, ram_re, ram_we, mem_busy},
                     4'b0000);
        end
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        step();
        idle();
        sample();
        n_checks++;
        if ({ld_valid, mem_rdata} !== {1'b1, 32'h12345678}) begin
            n_errors++;
            $display("FAIL merge_reset_word got %b/%h want 1/12345678", ld_valid, mem_rdata);
        end
        step();
    endtask

    task automatic test_rw_both();
        drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h4, 32'hCAFEF00D);
        sample();
        n_checks++;
        if ({ram_re, ram_we, ram_wdata} !== {2'b01, 32'hCAFEF00D}) begin
            n_errors++;
            $display("FAIL both_issue got %b/%h want 01/cafef00d", {ram_re, ram_we}, ram_wdata);
        end
        step();
        idle();
        sample();
        n_checks++;
        if (ld_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL both_no_load got %b want %b", ld_valid, 1'b0);
        end
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
        step();
        idle();
        sample();
        n_checks++;
        if ({ld_valid, mem_rdata} !== {1'b1, 32'hCAFEF00D}) begin
            n_errors++;
            $display("FAIL both_readback got %b/%h want 1/cafef00d", ld_valid, mem_rdata);
        end
        step();
    endtask

    task automatic test_random();
        bit          exp_ldv = 1'b0;
        bit          exp_mis = 1'b0;
        bit          in_merge = 1'b0;
        logic [31:0] exp_rd = 32'h0;
        logic [31:0] merge_word = 32'h0;
        logic [9:0]  merge_addr = 10'd0;
        for (int w = 0; w < 16; w++) begin
            logic [31:0] v;
            v = $urandom;
            drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h100 + 32'(4 * w), v);
            ref_store(32'h100 + 32'(4 * w), 4, v);
            step();
        end
        for (int i = 0; i < 400; i++) begin
            bit          rd, wr, sx, mis, nxt_ldv, nxt_mis, nxt_merge;
            logic [1:0]  md;
            logic [31:0] ad, wd, exp_wd, nxt_rd;
            logic [9:0]  exp_ad;
            logic [2:0]  exp_str;
            int unsigned sz;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            sx = 1'($urandom_range(0, 1));
            md = 2'($urandom_range(0, 3));
            ad = 32'h100 + $urandom_range(0, 63);
            wd = $urandom;
            sz = (md == 2'd0) ? 1 : (md == 2'd1) ? 2 : 4;
            mis = (ad % sz) != 0;
            exp_str = 3'b000;
            exp_wd = 32'h0;
            exp_ad = 10'd0;
            nxt_ldv = 1'b0;
            nxt_mis = 1'b0;
            nxt_merge = 1'b0;
            nxt_rd = 32'h0;
            if (in_merge) begin
                exp_str = 3'b011;
                exp_wd = merge_word;
                exp_ad = merge_addr;
            end else if (rd || wr) begin
                if (mis) begin
                    nxt_mis = 1'b1;
                end else if (wr) begin
                    ref_store(ad, sz, wd);
                    exp_ad = ad[11:2];
                    if (sz == 4) begin
                        exp_str = 3'b010;
                        exp_wd = wd;
                    end else begin
                        exp_str = 3'b101;
                        nxt_merge = 1'b1;
                        merge_word = ref_word(ad & 32'hFFFFFFFC);
                        merge_addr = ad[11:2];
                    end
                end else begin
                    exp_str = 3'b100;
                    exp_ad = ad[11:2];
                    nxt_ldv = 1'b1;
                    nxt_rd = ref_load(ad, sz, sx);
                end
            end
            drive(rd, wr, md, sx, ad, wd);
            sample();
            n_checks++;
            if ({ram_re, ram_we, mem_busy} !== exp_str) begin
                n_errors++;
                $display("FAIL rand_strobes_%0d got %b want %b", i, {ram_re, ram_we, mem_busy},
                         exp_str);
            end
            if (exp_str != 3'b000) begin
                n_checks++;
                if (ram_addr !== exp_ad) begin
                    n_errors++;
                    $display("FAIL rand_addr_%0d got %0d want %0d", i, ram_addr, exp_ad);
                end
            end
            if (exp_str[1]) begin
                n_checks++;
                if (ram_wdata !== exp_wd) begin
                    n_errors++;
                    $display("FAIL rand_wdata_%0d got %h want %h", i, ram_wdata, exp_wd);
                end
            end
            n_checks++;
            if ({ld_valid, mem_rdata} !== {exp_ldv, exp_ldv ? exp_rd : 32'h0}) begin
                n_errors++;
                $display("FAIL rand_load_%0d got %b/%h want %b/%h", i, ld_valid, mem_rdata,
                         exp_ldv, exp_ldv ? exp_rd : 32'h0);
            end
            n_checks++;
            if (misalign !== exp_mis) begin
                n_errors++;
                $display("FAIL rand_misalign_%0d got %b want %b", i, misalign, exp_mis);
            end
            exp_ldv = nxt_ldv;
            exp_rd = nxt_rd;
            exp_mis = nxt_mis;
            in_merge = nxt_merge;
            step();
        end
        idle();
        step();
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        ram_rdata = 32'h0;
        idle();
        test_reset();
        test_sb();
        test_sh();
        test_loads();
        test_sw_lw();
        test_reset_in_merge();
        test_rw_both();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
